// File: rtl/datamem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths
// and requester index constants.
package datamem_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/datamem_arbiter_arb_pick.sv
// Combinational winner selection between the CPU and loader requesters.
// On a tie the requester that was not granted last wins.
module arb_pick
  import datamem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  always_comb begin
    grant_o = REQ_CPU;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = REQ_LOADER;
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ISSUE -> HOLD -> ACK per transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the CPU always wins.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_q, state_d;
  logic                winner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant;
  logic                last_grant;
  logic                latch;

  assign latch = (state_q == IDLE) && (req0 || req1);

  arb_pick u_arb_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset value names the loader as last winner so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_LOADER;
    end else if (latch) begin
      last_q <= grant;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = REQ_LOADER;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state_q)
      IDLE:  if (req0 || req1) state_d = ISSUE;
      ISSUE: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        state_d   = HOLD;
      end
      HOLD:  state_d = ACK;
      ACK: begin
        ack0    = (winner_q == REQ_CPU);
        ack1    = (winner_q == REQ_LOADER);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction fields stay frozen from the latch until the next latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q <= REQ_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (latch) begin
        winner_q <= grant;
        we_q     <= grant ? we1    : we0;
        addr_q   <= grant ? addr1  : addr0;
        wdata_q  <= grant ? wdata1 : wdata0;
      end
      if ((state_q == HOLD) && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the data memory word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  SHALL carry the transaction requests; requester 0 is the CPU and requester 1 is the loader/debug port.
REQ-006 we0, we1  input  1 each  SHALL select write (1) or read (0) per requester.
REQ-007 addr0, addr1  input  ADDR_W each  SHALL carry the word address per requester.
REQ-008 wdata0, wdata1  input  DATA_W each  SHALL carry the write data per requester.
REQ-009 ack0, ack1  output  1 each  SHALL be the one-cycle completion pulse per requester.
REQ-010 rdata  output  DATA_W  SHALL carry the read data, valid while ack0 or ack1 is high after a read.
REQ-011 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_read, mem_write  output  1  SHALL drive the data memory port.
REQ-012 mem_rdata  input  DATA_W  SHALL carry the data memory read data.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, HOLD and ACK.
REQ-014 In IDLE with any req high at edge N, the arbiter SHALL latch the winner's index, we, addr and wdata, then enter ISSUE at N+1.
REQ-015 ISSUE SHALL assert exactly one of mem_read/mem_write for exactly one cycle, with mem_addr/mem_wdata stable from ISSUE until IDLE is re-entered.
REQ-016 HOLD SHALL deassert both strobes and, on a read, register mem_rdata into rdata.
REQ-017 ACK SHALL pulse the winner's ack for one cycle, then return to IDLE; latency from req sample to ack is 3 cycles and throughput is at most one transaction per 4 cycles.
REQ-018 Requesters SHALL hold req/we/addr/wdata until ack; once latched, a transaction completes and acks even if req drops.
REQ-019 A requester still holding req in the ACK cycle SHALL be treated as a new request at the next IDLE.
REQ-020 mem_read and mem_write SHALL never be high simultaneously, and no strobe SHALL be high outside ISSUE.
REQ-021 rdata SHALL hold its last value after a write transaction and between transactions.

Reset
REQ-022 While rst is low, the FSM SHALL be in IDLE, all strobes and acks 0, mem_addr/mem_wdata/rdata 0, and the RR pointer favouring requester 0.
REQ-023 Reset asserted mid-transaction SHALL drop strobes immediately (asynchronously), abort the transaction and issue no ack.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, on simultaneous requests the requester not granted most recently SHALL win, with the pointer updated at each latch.
REQ-025 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win on simultaneous requests, and no pointer register SHALL exist.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, ISSUE=1, HOLD=2, ACK=3), the ADDR_W/DATA_W defaults and the requester index constants.
REQ-027 Winner selection SHALL be a combinational sub-module arb_pick (inputs: req0, req1, last-grant; output: grant index).

Verification
REQ-028 Reset; req0 we0=1 addr0=5 wdata0=0xDEADBEEF -> mem_write one cycle at N+1 with mem_addr=5; ack0 at N+3; ack1 stays 0.
REQ-029 Then req1 we1=0 addr1=5 -> mem_read one cycle; rdata=0xDEADBEEF with ack1 at N+3.
REQ-030 req0 and req1 high continuously: with RR the grants alternate 0,1,0,1; without RR, only ack0 pulses.
REQ-031 Assert rst low during HOLD -> strobes 0 at once, no ack, state IDLE; after release, a fresh req0 completes normally.
REQ-032 Drop req0 in the cycle after the latch -> the transaction still completes and ack0 pulses at N+3.
REQ-033 Assertion run across all tests: strobes never overlap; every strobe is exactly one cycle; each latched transaction yields exactly one ack.
